// File: rtl/rr_arbiter8.sv
// rr_arbiter8: round-robin arbiter sharing one resource among 8 requesters.
// A winner keeps the grant until it drops its request or the hold limit
// expires; every release is followed by one idle (bubble) cycle, and the
// priority pointer then moves to the requester just after the old grantee.
//
// Handshake: req[i] is a level request held high for as long as requester i
// needs the resource; gnt[i] (registered) tells it that it owns the resource.
// A grant is only issued from IDLE, so the one-cycle bubble is guaranteed.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout,
  output logic       state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    gnt_d;
  logic [2:0]    idx_d;
  logic          busy_d;
  logic          timeout_d;

  logic [15:0]   req_dbl;
  logic [7:0]    req_rot;
  logic [2:0]    offset;
  logic [2:0]    winner;
  logic          any_req;
  logic          own_req;
  logic          at_limit;

  // FSM state is visible to checkers: 1 while a grant tenure is active.
  assign state_dbg = (state_q == GRANT);

  // Rotate the request vector so bit 0 is the requester at ptr, then pick the
  // lowest set bit; adding ptr back gives the winner with natural 3-bit wrap.
  always_comb begin
    req_dbl = {req, req};
    req_rot = req_dbl[ptr_q +: 8];
    offset  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        offset = i[2:0];
      end
    end
    winner  = ptr_q + offset;
    any_req = (req != 8'd0);
  end

  // Status of the current tenure: does the grantee still want it, and has it
  // used up its hold budget (never, when the limit is disabled).
  always_comb begin
    own_req  = req[gnt_idx];
    at_limit = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);
  end

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt;
    idx_d     = gnt_idx;
    busy_d    = busy;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = winner;
          gnt_d   = 8'd1 << winner;
          busy_d  = 1'b1;
          cnt_d   = CW'(1);
        end
      end
      GRANT: begin
        if (!own_req) begin
          // Voluntary release.
          state_d = IDLE;
          gnt_d   = 8'd0;
          busy_d  = 1'b0;
          ptr_d   = gnt_idx + 3'd1;
        end else if (at_limit) begin
          // Forced release: hold budget exhausted while still requesting.
          state_d   = IDLE;
          gnt_d     = 8'd0;
          busy_d    = 1'b0;
          ptr_d     = gnt_idx + 3'd1;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          // Keep counting; with the limit disabled the counter saturates.
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      gnt     <= 8'd0;
      gnt_idx <= 3'd0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      gnt_idx <= idx_d;
      busy    <= busy_d;
      timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: three instances (hold limits 4, 3 and disabled)
// driven side by side. A behavioural model predicts every instance's outputs
// per cycle; predictions are queued at drive time and popped after the edge.
module tb_rr_arbiter8;

  localparam int W = 13;  // {timeout, busy, gnt_idx[2:0], gnt[7:0]}

  logic       clk;
  logic       rst;
  logic [7:0] req_a, req_b, req_c;
  logic [7:0] gnt_a, gnt_b, gnt_c;
  logic [2:0] idx_a, idx_b, idx_c;
  logic       busy_a, busy_b, busy_c;
  logic       to_a, to_b, to_c;
  logic       st_a, st_b, st_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3*W-1:0] exp_q[$];

  // model state per instance: 0 -> MAX_HOLD=4, 1 -> 3, 2 -> 0 (disabled)
  int m_hold[3] = '{4, 3, 0};
  int m_busy[3];
  int m_idx[3];
  int m_ptr[3];
  int m_cnt[3];
  int m_to[3];

  rr_arbiter8 #(.MAX_HOLD(4), .CW(5)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_idx(idx_a),
    .busy(busy_a), .timeout(to_a), .state_dbg(st_a));
  rr_arbiter8 #(.MAX_HOLD(3), .CW(5)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_idx(idx_b),
    .busy(busy_b), .timeout(to_b), .state_dbg(st_b));
  rr_arbiter8 #(.MAX_HOLD(0), .CW(5)) u_dut_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_idx(idx_c),
    .busy(busy_c), .timeout(to_c), .state_dbg(st_c));

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One cycle of the reference behaviour for instance k.
  task automatic model_step(input int k, input logic [7:0] r);
    if (rst) begin
      m_busy[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_to[k] = 0;
    end else begin
      m_to[k] = 0;
      if (m_busy[k] == 0) begin
        for (int j = 0; j < 8; j++) begin
          int c;
          c = (m_ptr[k] + j) % 8;
          if (r[c]) begin
            m_idx[k] = c; m_busy[k] = 1; m_cnt[k] = 1;
            break;
          end
        end
      end else if (!r[m_idx[k]]) begin
        m_busy[k] = 0;
        m_ptr[k]  = (m_idx[k] + 1) % 8;
      end else if (m_hold[k] != 0 && m_cnt[k] >= m_hold[k]) begin
        m_busy[k] = 0;
        m_to[k]   = 1;
        m_ptr[k]  = (m_idx[k] + 1) % 8;
      end else begin
        m_cnt[k]++;
      end
    end
  endtask

  function automatic logic [W-1:0] model_out(input int k);
    logic [7:0] g;
    logic [2:0] ix;
    ix = 3'(m_idx[k]);
    g  = (m_busy[k] != 0) ? (8'd1 << ix) : 8'd0;
    return {m_to[k] != 0, m_busy[k] != 0, ix, g};
  endfunction

  // driver: predict, push, clock, then pop and compare after the edge
  task automatic tick();
    logic [3*W-1:0] e;
    logic [7:0] rq[3];
    rq[0] = req_a; rq[1] = req_b; rq[2] = req_c;
    for (int k = 0; k < 3; k++) begin
      model_step(k, rq[k]);
      e[k*W +: W] = model_out(k);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("dut_a", {19'd0, to_a, busy_a, idx_a, gnt_a}, {19'd0, e[0 +: W]});
    check("dut_b", {19'd0, to_b, busy_b, idx_b, gnt_b}, {19'd0, e[W +: W]});
    check("dut_c", {19'd0, to_c, busy_c, idx_c, gnt_c}, {19'd0, e[2*W +: W]});
    check("onehot_a", 32'($onehot0(gnt_a)), 32'd1);
    check("onehot_b", 32'($onehot0(gnt_b)), 32'd1);
    check("onehot_c", 32'($onehot0(gnt_c)), 32'd1);
    check("state_a", 32'(st_a), 32'(e[W-2]));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    int seq_n;
    int run_len;
    logic prev_busy;
    rst = 1'b1; req_a = 8'd0; req_b = 8'd0; req_c = 8'd0;
    @(posedge clk); #1;

    // reset state, then single request on line 3
    do_reset(2);
    check("rst_gnt", 32'(gnt_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    req_a = 8'h08; tick();
    check("single_gnt", 32'(gnt_a), 32'h08);
    check("single_idx", 32'(idx_a), 32'd3);
    req_a = 8'h00; tick();
    check("single_rel", 32'(gnt_a), 32'h0);
    check("idle_idx_kept", 32'(idx_a), 32'd3);
    req_a = 8'h18; tick();
    check("ptr_after_3", 32'(idx_a), 32'd4);
    req_a = 8'h00; tick();

    // rotation with all lines requesting, hold limit 4
    do_reset(1);
    req_a = 8'hFF;
    seq_n = 0; run_len = 0; prev_busy = 1'b0;
    repeat (45) begin
      tick();
      if (busy_a && !prev_busy) begin
        check("rot_idx", 32'(idx_a), 32'(seq_n % 8));
        seq_n++;
        run_len = 0;
      end
      if (busy_a) run_len++;
      if (!busy_a && prev_busy) begin
        check("rot_len", 32'(run_len), 32'd4);
        check("rot_timeout", 32'(to_a), 32'd1);
      end
      prev_busy = busy_a;
    end
    check("rot_count", 32'(seq_n), 32'd9);
    req_a = 8'h00; tick(); tick();

    // priority after release
    do_reset(1);
    req_a = 8'h04; tick();
    check("prio_g2", 32'(idx_a), 32'd2);
    req_a = 8'h00; tick();
    req_a = 8'h22; tick();
    check("prio_g5", 32'(idx_a), 32'd5);
    tick();
    req_a = 8'h02; tick();
    check("prio_bubble", 32'(gnt_a), 32'h0);
    tick();
    check("prio_g1", 32'(gnt_a), 32'h02);
    req_a = 8'h00; tick();

    // reset in the middle of a grant
    req_a = 8'h40; tick(); tick();
    check("mid_g6", 32'(gnt_a), 32'h40);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst", {28'd0, to_a, busy_a, idx_a == 3'd0, gnt_a == 8'd0}, 32'h3);
    req_a = 8'h41; tick();
    check("mid_g0", 32'(idx_a), 32'd0);
    req_a = 8'h00; tick();

    // sole requester with hold limit 3: period of 4
    do_reset(1);
    req_b = 8'h01;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("sole_gnt", 32'(gnt_b), (i % 4 != 3) ? 32'h01 : 32'h00);
      check("sole_to", 32'(to_b), (i % 4 != 3) ? 32'd0 : 32'd1);
    end
    req_b = 8'h00; tick();

    // limit disabled: grant kept for 100 cycles, never times out
    do_reset(1);
    req_c = 8'h10;
    repeat (100) begin
      tick();
      check("nolim_gnt", 32'(gnt_c), 32'h10);
      check("nolim_to", 32'(to_c), 32'd0);
    end
    req_c = 8'h00; tick();

    // random traffic on all instances
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 60) == 0);
      req_a = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      req_b = 8'($urandom_range(0, 255));
      req_c = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : req_c;
      tick();
    end
    rst = 1'b0;

    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
